seven_segment_monitor: RTL and testbench
========================================

// Module: seven_segment_monitor
// PURPOSE
// - Receive-side companion to the dual-digit counter/display path.
// - Samples both digits' active-low 7-segment pin patterns, waits until each new pattern is stable,
//   decodes it back to two BCD digits and reports it with a one-cycle valid strobe.
// - Checks that successive accepted values follow the counter's sequence, and counts violations.
// - Used as an on-chip self-check monitor and as the bench scoreboard front end.
// PARAMETERS
// - STABLE_CYCLES  default 4  consecutive identical samples required before acceptance (>=1)
// - ERR_W          default 8  width of the saturating error counter
// PORTS
// - i_Clk          in   1      single clock
// - i_Reset        in   1      synchronous, active-high reset
// - i_Segment1     in   7      tens digit pins, active-low; bit0=A .. bit6=G
// - i_Segment2     in   7      ones digit pins, active-low; bit0=A .. bit6=G
// - o_Tens         out  4      last accepted valid tens digit
// - o_Ones         out  4      last accepted valid ones digit
// - o_Valid        out  1      1-cycle pulse: new valid value accepted
// - o_Invalid      out  1      level: currently accepted pattern is not decodable
// - o_Seq_Error    out  1      1-cycle pulse, coincident with o_Valid: sequence violation
// - o_Error_Count  out  ERR_W  saturating count of o_Seq_Error pulses
// BEHAVIOUR
// - Reset: all outputs 0; sample register = 0x7F/0x7F (all segments off); no baseline; stability counter 0; FSM S_SETTLE.
// - Inputs are inverted to active-high and registered once per cycle (sample s[t]).
// - The stability counter clears when s[t] != s[t-1] and otherwise increments.
//   - It saturates at STABLE_CYCLES.
//   - It affects only the {tens,ones} 14-bit pattern as a whole.
// - FSM S_SETTLE -> S_HOLD when the counter reaches STABLE_CYCLES-1 and s equals s[t-1]:
//   - Acceptance occurs on that cycle.
//   - Outputs update on the next edge.
//   - Latency: inputs change at edge t -> o_Valid high for cycle t+1+STABLE_CYCLES.
// - S_HOLD -> S_SETTLE when any sample bit changes. The same pattern is never re-accepted while held.
// - Decode table, active-high {G..A}: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F.
// - Any other pattern, including blank 00, is invalid. Invalid acceptance:
//   - o_Invalid=1, no o_Valid.
//   - o_Tens/o_Ones hold their previous values.
//   - The baseline is cleared.
// - Valid acceptance:
//   - o_Tens/o_Ones update, o_Invalid=0, o_Valid pulses.
//   - If a baseline exists, the new value must equal baseline+1 (mod 100) or 00.
//   - Otherwise o_Seq_Error pulses with o_Valid.
//   - The baseline becomes the new value.
// - Error counter increments on each o_Seq_Error and saturates at 2^ERR_W-1. It clears only on reset.
// - The first valid value after reset or after an invalid pattern is never a sequence error.
// - Reset mid-settle: acceptance is abandoned, no pulse is emitted, and all state returns to reset values the next cycle.
// - 99 -> 00 is a legal wrap. Any value -> 00 is a legal counter clear.
// CONFIGURATION
// - Optional macro SEVEN_SEG_MONITOR_HEX_EN.
// - Defined:
//   - The table adds A=77 b=7C C=39 d=5E E=79 F=71.
//   - The sequence rule becomes baseline+1 mod 256, with the ones digit wrapping at F.
// - Undefined:
//   - Those patterns are invalid.
//   - Decimal rules apply.
// STRUCTURE
// - Package seven_seg_pkg:
//   - The 16 pattern localparams.
//   - The FSM state encoding (S_SETTLE, S_HOLD).
//   - The segment bit-index constants.
// - Sub-module seven_seg_pattern_decode: combinational 7-bit pattern -> {4-bit digit, valid}.
//   - Honours SEVEN_SEG_MONITOR_HEX_EN.
//   - Instantiated twice (tens, ones).
// TESTING (STABLE_CYCLES=4)
// - Reset, then drive "0","0" stable -> o_Valid 1 cycle at t+5, o_Tens=0, o_Ones=0, o_Seq_Error=0.
// - Step 00->01->...->99->00, holding each for 10 cycles -> 100 valid pulses, 0 errors, o_Error_Count=0.
// - Drive 05 then 07 -> o_Valid with o_Seq_Error=1; o_Error_Count=1. Then 08 -> no error.
// - Toggle the ones digit every 3 cycles -> no o_Valid; then hold 10 cycles -> a single accept.
// - Drive ones pattern 0x49 (invalid) -> o_Invalid=1, digits hold. Next 42 -> valid, no seq error.
// - With HEX_EN: 09 -> 0A accepted without error; 0F -> 10 legal. Without HEX_EN: 0A -> o_Invalid=1.
// - Assert i_Reset 2 cycles into a settle -> no o_Valid; all outputs 0 the next cycle.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment receive monitor: segment patterns, bit indices,
// FSM encoding and the counter sequence helper (honours SEVEN_SEG_MONITOR_HEX_EN).
package seven_seg_pkg;

  localparam int SEG_A_BIT = 0;
  localparam int SEG_B_BIT = 1;
  localparam int SEG_C_BIT = 2;
  localparam int SEG_D_BIT = 3;
  localparam int SEG_E_BIT = 4;
  localparam int SEG_F_BIT = 5;
  localparam int SEG_G_BIT = 6;
  localparam int SEG_W     = SEG_G_BIT + 1;

  // Active-high {G..A} patterns
  localparam logic [SEG_W-1:0] SEG_0 = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_1 = 7'h06;
  localparam logic [SEG_W-1:0] SEG_2 = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_3 = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_4 = 7'h66;
  localparam logic [SEG_W-1:0] SEG_5 = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_6 = 7'h7D;
  localparam logic [SEG_W-1:0] SEG_7 = 7'h07;
  localparam logic [SEG_W-1:0] SEG_8 = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_9 = 7'h6F;
  localparam logic [SEG_W-1:0] SEG_HEX_A = 7'h77;
  localparam logic [SEG_W-1:0] SEG_HEX_B = 7'h7C;
  localparam logic [SEG_W-1:0] SEG_HEX_C = 7'h39;
  localparam logic [SEG_W-1:0] SEG_HEX_D = 7'h5E;
  localparam logic [SEG_W-1:0] SEG_HEX_E = 7'h79;
  localparam logic [SEG_W-1:0] SEG_HEX_F = 7'h71;

  typedef enum logic {
    S_SETTLE = 1'b0,
    S_HOLD   = 1'b1
  } state_t;

  // Value the display counter shows after {tens,ones}
  function automatic logic [7:0] seq_next(input logic [3:0] tens, input logic [3:0] ones);
`ifdef SEVEN_SEG_MONITOR_HEX_EN
    return {tens, ones} + 8'd1;
`else
    if (ones != 4'd9)
      return {tens, ones + 4'd1};
    else if (tens != 4'd9)
      return {tens + 4'd1, 4'd0};
    else
      return 8'h00;
`endif
  endfunction

endpackage

// File: rtl/seven_segment_monitor_if.sv
// Pin-side and report-side signals of the seven-segment monitor; the monitor is the slave.
interface seven_segment_monitor_if #(
  parameter int ERR_W = 8
);
  import seven_seg_pkg::*;

  logic [SEG_W-1:0] i_Segment1;
  logic [SEG_W-1:0] i_Segment2;
  logic [3:0]       o_Tens;
  logic [3:0]       o_Ones;
  logic             o_Valid;
  logic             o_Invalid;
  logic             o_Seq_Error;
  logic [ERR_W-1:0] o_Error_Count;

  modport master (
    output i_Segment1, i_Segment2,
    input  o_Tens, o_Ones, o_Valid, o_Invalid, o_Seq_Error, o_Error_Count
  );

  modport slave (
    input  i_Segment1, i_Segment2,
    output o_Tens, o_Ones, o_Valid, o_Invalid, o_Seq_Error, o_Error_Count
  );
endinterface

// File: rtl/seven_seg_pattern_decode.sv
// Combinational active-high segment pattern -> digit decoder.
// SEVEN_SEG_MONITOR_HEX_EN adds the A..F glyphs.
module seven_seg_pattern_decode
  import seven_seg_pkg::*;
(
  input  logic [SEG_W-1:0] pattern,
  output logic [3:0]       digit,
  output logic             valid
);

  always_comb begin
    digit = 4'd0;
    valid = 1'b1;
    case (pattern)
      SEG_0: digit = 4'd0;
      SEG_1: digit = 4'd1;
      SEG_2: digit = 4'd2;
      SEG_3: digit = 4'd3;
      SEG_4: digit = 4'd4;
      SEG_5: digit = 4'd5;
      SEG_6: digit = 4'd6;
      SEG_7: digit = 4'd7;
      SEG_8: digit = 4'd8;
      SEG_9: digit = 4'd9;
`ifdef SEVEN_SEG_MONITOR_HEX_EN
      SEG_HEX_A: digit = 4'hA;
      SEG_HEX_B: digit = 4'hB;
      SEG_HEX_C: digit = 4'hC;
      SEG_HEX_D: digit = 4'hD;
      SEG_HEX_E: digit = 4'hE;
      SEG_HEX_F: digit = 4'hF;
`endif
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/seven_segment_monitor.sv
// Seven-segment receive monitor: debounces the two digit patterns, decodes them and checks
// the counter sequence. SEVEN_SEG_MONITOR_HEX_EN selects hex digits and mod-256 sequencing.
module seven_segment_monitor
  import seven_seg_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int ERR_W         = 8
) (
  input logic                    i_Clk,
  input logic                    i_Reset,
  seven_segment_monitor_if.slave bus
);

  localparam int                CNT_W   = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_HIT = CNT_W'(STABLE_CYCLES - 1);

  logic [2*SEG_W-1:0] samp_p0, samp_p1;
  logic [CNT_W-1:0]   stab_cnt;
  state_t             state, state_nxt;
  logic               changed, stable_hit, accept;
  logic [3:0]         tens_dig, ones_dig;
  logic               tens_ok, ones_ok;
  logic               seq_bad, base_vld;
  logic [7:0]         expect_val;
  logic [3:0]         tens_q, ones_q;
  logic               valid_q, invalid_q, seq_err_q;
  logic [ERR_W-1:0]   err_cnt_q;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Stage p0/p1: raw active-low pins and their previous sample; stability run counter
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      samp_p0  <= '1;
      samp_p1  <= '1;
      stab_cnt <= '0;
    end else begin
      samp_p0 <= {bus.i_Segment1, bus.i_Segment2};
      samp_p1 <= samp_p0;
      if (changed)
        stab_cnt <= '0;
      else if (stab_cnt != CNT_MAX)
        stab_cnt <= stab_cnt + 1'b1;
    end
  end

  assign changed    = (samp_p0 != samp_p1);
  assign stable_hit = !changed && (stab_cnt == CNT_HIT);

  seven_seg_pattern_decode u_dec_tens (
    .pattern (~samp_p0[2*SEG_W-1:SEG_W]),
    .digit   (tens_dig),
    .valid   (tens_ok)
  );

  seven_seg_pattern_decode u_dec_ones (
    .pattern (~samp_p0[SEG_W-1:0]),
    .digit   (ones_dig),
    .valid   (ones_ok)
  );

  always_ff @(posedge i_Clk) begin
    if (i_Reset) state <= S_SETTLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_SETTLE: if (stable_hit) state_nxt = S_HOLD;
      S_HOLD:   if (changed)    state_nxt = S_SETTLE;
      default:                  state_nxt = S_SETTLE;
    endcase
  end

  always_comb begin
    accept = (state == S_SETTLE) && stable_hit;
  end

  // Displayed value doubles as the baseline; a clear to 00 is always legal
  assign expect_val = seq_next(tens_q, ones_q);
  assign seq_bad    = base_vld && ({tens_dig, ones_dig} != expect_val) &&
                      ({tens_dig, ones_dig} != 8'h00);

  // Stage p2: reported outputs
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      tens_q    <= '0;
      ones_q    <= '0;
      valid_q   <= 1'b0;
      invalid_q <= 1'b0;
      seq_err_q <= 1'b0;
      err_cnt_q <= '0;
      base_vld  <= 1'b0;
    end else begin
      valid_q   <= 1'b0;
      seq_err_q <= 1'b0;
      if (accept) begin
        if (tens_ok && ones_ok) begin
          tens_q    <= tens_dig;
          ones_q    <= ones_dig;
          invalid_q <= 1'b0;
          valid_q   <= 1'b1;
          seq_err_q <= seq_bad;
          base_vld  <= 1'b1;
          if (seq_bad) err_cnt_q <= sat_inc(err_cnt_q);
        end else begin
          invalid_q <= 1'b1;
          base_vld  <= 1'b0;
        end
      end
    end
  end

  assign bus.o_Tens        = tens_q;
  assign bus.o_Ones        = ones_q;
  assign bus.o_Valid       = valid_q;
  assign bus.o_Invalid     = invalid_q;
  assign bus.o_Seq_Error   = seq_err_q;
  assign bus.o_Error_Count = err_cnt_q;

endmodule

// File: tb/tb_seven_segment_monitor.sv
// Scoreboard bench for seven_segment_monitor: run-length acceptance model feeds an expectation
// queue, an output monitor pops and compares. Follows SEVEN_SEG_MONITOR_HEX_EN when defined.
`timescale 1ns/1ps
module tb_seven_segment_monitor;

  localparam int STABLE_CYCLES = 4;
  localparam int ERR_W         = 4;
`ifdef SEVEN_SEG_MONITOR_HEX_EN
  localparam int RADIX = 16;
`else
  localparam int RADIX = 10;
`endif
  localparam int MODV    = RADIX * RADIX;
  localparam int ERR_MAX = (1 << ERR_W) - 1;

  logic i_Clk = 1'b0;
  logic i_Reset;

  seven_segment_monitor_if #(.ERR_W(ERR_W)) bus ();

  seven_segment_monitor #(
    .STABLE_CYCLES (STABLE_CYCLES),
    .ERR_W         (ERR_W)
  ) dut (
    .i_Clk   (i_Clk),
    .i_Reset (i_Reset),
    .bus     (bus)
  );

  always #5 i_Clk = ~i_Clk;

  logic [6:0] pat_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  typedef struct {
    int cyc;
    bit inv;
    int tens;
    int ones;
    bit seq;
    int errc;
  } exp_t;

  exp_t q[$];
  int   checks  = 0;
  int   errors  = 0;
  int   cyc     = 0;
  int   n_valid = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Digit shown by a set of active-low pins, or -1 when it is not a legal glyph
  function automatic int dec(input logic [6:0] pins);
    logic [6:0] p;
    p = ~pins;
    for (int i = 0; i < RADIX; i++)
      if (pat_tbl[i] == p) return i;
    return -1;
  endfunction

  // Reference model: a pattern is accepted once it has been sampled STABLE_CYCLES+1 times in a row
  logic [13:0] m_last;
  int          m_run;
  bit          m_acc, m_inv, m_bvld;
  int          m_base, m_tens, m_ones, m_err;

  always @(posedge i_Clk) begin
    logic [13:0] s;
    int          dt, od, num;
    exp_t        e;
    cyc++;
    if (i_Reset) begin
      q.delete();
      m_last = '1; m_run = 1; m_acc = 0; m_inv = 0; m_bvld = 0;
      m_base = 0; m_tens = 0; m_ones = 0; m_err = 0;
    end else begin
      s = {bus.i_Segment1, bus.i_Segment2};
      if (s == m_last) m_run++;
      else begin
        m_run = 1; m_acc = 0; m_last = s;
      end
      if (!m_acc && m_run == STABLE_CYCLES + 1) begin
        m_acc = 1;
        dt = dec(s[13:7]);
        od = dec(s[6:0]);
        e.cyc = cyc + 1;
        if (dt >= 0 && od >= 0) begin
          num   = dt * RADIX + od;
          e.seq = m_bvld && (num != 0) && (num != (m_base + 1) % MODV);
          if (e.seq && m_err < ERR_MAX) m_err++;
          m_tens = dt; m_ones = od; m_base = num; m_bvld = 1; m_inv = 0;
          e.inv = 0; e.tens = dt; e.ones = od; e.errc = m_err;
          q.push_back(e);
        end else begin
          m_bvld = 0;
          if (!m_inv) begin
            e.inv = 1; e.tens = m_tens; e.ones = m_ones; e.seq = 0; e.errc = m_err;
            q.push_back(e);
          end
          m_inv = 1;
        end
      end
    end
  end

  // Output monitor: a valid pulse or a rising invalid flag is a DUT report
  bit inv_d = 0;
  always @(negedge i_Clk) begin
    exp_t e;
    checks++;
    if (bus.o_Seq_Error && !bus.o_Valid) begin
      errors++;
      $display("FAIL seq_err_without_valid: got o_Seq_Error=1 o_Valid=0, required no error pulse (cycle %0d)", cyc);
    end
    if (bus.o_Valid) n_valid++;
    if (bus.o_Valid || (bus.o_Invalid && !inv_d)) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_report: got valid=%0b invalid=%0b tens=%0d ones=%0d, required none (cycle %0d)",
                 bus.o_Valid, bus.o_Invalid, bus.o_Tens, bus.o_Ones, cyc);
      end else begin
        e = q.pop_front();
        chk("report_cycle", cyc, e.cyc);
        chk("report_invalid", int'(bus.o_Invalid), int'(e.inv));
        chk("report_valid", int'(bus.o_Valid), int'(!e.inv));
        chk("report_tens", int'(bus.o_Tens), e.tens);
        chk("report_ones", int'(bus.o_Ones), e.ones);
        chk("report_seq_err", int'(bus.o_Seq_Error), int'(e.seq));
        chk("report_err_count", int'(bus.o_Error_Count), e.errc);
      end
    end
    inv_d = bus.o_Invalid;
  end

  task automatic drive_raw(input logic [6:0] p1, input logic [6:0] p2, input int hold);
    bus.i_Segment1 = p1;
    bus.i_Segment2 = p2;
    repeat (hold) @(negedge i_Clk);
  endtask

  task automatic drive(input int t, input int o, input int hold);
    drive_raw(~pat_tbl[t], ~pat_tbl[o], hold);
  endtask

  task automatic drain(input string name);
    #1;
    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge i_Clk);
    #1;
    chk(name, q.size(), 0);
    q.delete();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_tens"},    int'(bus.o_Tens), 0);
    chk({tag, "_ones"},    int'(bus.o_Ones), 0);
    chk({tag, "_valid"},   int'(bus.o_Valid), 0);
    chk({tag, "_invalid"}, int'(bus.o_Invalid), 0);
    chk({tag, "_seq"},     int'(bus.o_Seq_Error), 0);
    chk({tag, "_errcnt"},  int'(bus.o_Error_Count), 0);
  endtask

  // Reset with the given digits already on the pins
  task automatic reset_dut(input int t, input int o);
    bus.i_Segment1 = ~pat_tbl[t];
    bus.i_Segment2 = ~pat_tbl[o];
    i_Reset = 1'b1;
    repeat (2) @(negedge i_Clk);
    check_zero("reset");
    i_Reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int v0, v, r, hold;
    i_Reset = 1'b1;
    bus.i_Segment1 = ~pat_tbl[0];
    bus.i_Segment2 = ~pat_tbl[0];
    @(negedge i_Clk);
    reset_dut(0, 0);
    repeat (10) @(negedge i_Clk);
    drain("first_accept");
    chk("first_tens", int'(bus.o_Tens), 0);

    // Walk the whole counter sequence including the wrap
    v0 = n_valid;
    for (int k = 1; k <= MODV; k++) drive((k % MODV) / RADIX, k % RADIX, 10);
    drain("walk_drain");
    chk("walk_valid_count", n_valid - v0, MODV);
    chk("walk_err_count", int'(bus.o_Error_Count), 0);

    reset_dut(0, 5);
    drive(0, 5, 10);
    drive(0, 7, 10);
    drain("skip_drain");
    chk("skip_err_count", int'(bus.o_Error_Count), 1);
    drive(0, 8, 10);
    drain("after_skip_drain");
    chk("after_skip_err_count", int'(bus.o_Error_Count), 1);

    // Bouncing ones digit must not be accepted until it settles
    v0 = n_valid;
    for (int k = 0; k < 10; k++) drive(0, (k % 2) ? 7 : 9, 3);
    drive(0, 9, 10);
    drain("bounce_drain");
    chk("bounce_single_accept", n_valid - v0, 1);

    drive_raw(~pat_tbl[0], ~7'h49, 10);
    drain("invalid_drain");
    chk("invalid_level", int'(bus.o_Invalid), 1);
    chk("invalid_hold_tens", int'(bus.o_Tens), 0);
    chk("invalid_hold_ones", int'(bus.o_Ones), 9);
    drive(4, 2, 10);
    drain("recover_drain");
    chk("recover_invalid", int'(bus.o_Invalid), 0);
    chk("recover_err_count", int'(bus.o_Error_Count), 1);

    drive(0, 9, 10);
    drive(0, 10, 10);
    drain("hex_a_drain");
    chk("hex_a_invalid", int'(bus.o_Invalid), (RADIX == 10) ? 1 : 0);
    drive(0, 15, 10);
    drive(1, 0, 10);
    drain("hex_wrap_drain");

    // Randomized traffic: mostly legal steps, some jumps, clears, garbage and short glitches
    v = 10;
    for (int k = 0; k < 300; k++) begin
      r    = $urandom_range(0, 9);
      hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : $urandom_range(6, 9);
      if (r <= 5) begin
        v = (v + 1) % MODV;
        drive(v / RADIX, v % RADIX, hold);
      end else if (r == 6) begin
        v = 0;
        drive(0, 0, hold);
      end else if (r <= 8) begin
        v = $urandom_range(0, MODV - 1);
        drive(v / RADIX, v % RADIX, hold);
      end else begin
        drive_raw(~pat_tbl[v / RADIX], 7'($urandom_range(0, 127)), hold);
      end
    end
    drive(3, 3, 10);
    drain("random_drain");

    // Reset two cycles into a settle: no report, everything back to zero
    drive(1, 1, 2);
    i_Reset = 1'b1;
    @(negedge i_Clk);
    check_zero("midsettle");
    drive(1, 2, 1);
    i_Reset = 1'b0;
    repeat (10) @(negedge i_Clk);
    drain("post_reset_drain");
    chk("post_reset_tens", int'(bus.o_Tens), 1);
    chk("post_reset_ones", int'(bus.o_Ones), 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
